conv_mac_unit: RTL and testbench

Parametrised memory-mapped convolution engine: the next generation of the fixed 64-bit convolution peripheral. It holds a kernel of N_TAPS elements and a sliding data window of matching length. Each data write pushes a sample and starts a sequential multiply-accumulate pass, one tap per cycle, and produces a RES_W-bit result. It sits as a slave on the core's MMIO request/response bus, beside the other peripherals.

---
 rtl/conv_mac_unit_if.sv | 36 +++
 rtl/conv_mac_unit.sv | 208 ++++++++++++++++++++
 tb/tb_conv_mac_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_unit_if.sv
// conv_mac_unit_if: MMIO request/response bus between the core (master)
// and a peripheral (slave). One request per cycle, read data one cycle later.
interface conv_mac_unit_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );

endinterface

// File: rtl/conv_mac_unit.sv
// conv_mac_unit: memory-mapped convolution engine. Holds an N_TAPS kernel and a
// sliding sample window; every DATA write pushes a sample and runs a sequential
// multiply-accumulate pass (one tap per cycle) producing a RES_W-bit result.
// Optional feature macro: CONV_SIGNED_EN (two's-complement elements/products);
// when undefined all arithmetic is unsigned.
module conv_mac_unit #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned N_TAPS = 8,
    parameter int unsigned RES_W  = 128
) (
    input  logic           clk,
    input  logic           rstn,
    conv_mac_unit_if.slave bus,
    output logic           busy
);

    localparam int unsigned PROD_W = 2 * ELEM_W;
    localparam int unsigned IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int unsigned CNT_W  = 32;

    localparam logic [ADDR_W-1:0] A_KERNEL = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_STATE  = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] A_RES_LO = ADDR_W'(32'h18);
    localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(32'h20);

    // Elaboration-time parameter sanity checks
    if (ELEM_W * N_TAPS > DATA_W) begin : g_chk_pack
        $error("conv_mac_unit: ELEM_W*N_TAPS must fit in DATA_W");
    end
    if (N_TAPS < 2) begin : g_chk_taps
        $error("conv_mac_unit: N_TAPS must be at least 2");
    end
    if (RES_W > 2 * DATA_W) begin : g_chk_res_max
        $error("conv_mac_unit: RES_W must not exceed 2*DATA_W");
    end
    if (RES_W < PROD_W) begin : g_chk_res_min
        $error("conv_mac_unit: RES_W must hold a full product");
    end
    if (DATA_W < 64) begin : g_chk_data
        $error("conv_mac_unit: DATA_W must be at least 64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [ELEM_W-1:0]   kern_q [N_TAPS];
    logic [ELEM_W-1:0]   win_q  [N_TAPS];
    logic [IDX_W-1:0]    idx_q;
    logic [RES_W-1:0]    acc_q;
    logic [RES_W-1:0]    result_q;
    logic                done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    logic [ADDR_W-1:0]   addr_c;
    logic                is_kernel_c;
    logic                is_data_c;
    logic                is_state_c;
    logic                is_res_lo_c;
    logic                is_res_hi_c;
    logic                ctrl_wr_c;
    logic                req_ready_c;
    logic                rd_fire_c;
    logic                wr_fire_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic [ELEM_W-1:0]   k_el_c;
    logic [ELEM_W-1:0]   w_el_c;
    logic [RES_W-1:0]    term_c;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^bus.req_addr[2:0];

    // Address decode and handshake: control-register writes only land in IDLE
    always_comb begin
        addr_c      = {bus.req_addr[ADDR_W-1:3], 3'b000};
        is_kernel_c = (addr_c == A_KERNEL);
        is_data_c   = (addr_c == A_DATA);
        is_state_c  = (addr_c == A_STATE);
        is_res_lo_c = (addr_c == A_RES_LO);
        is_res_hi_c = (addr_c == A_RES_HI);
        ctrl_wr_c   = bus.req_we & (is_kernel_c | is_data_c | is_state_c);
        req_ready_c = rstn & (~ctrl_wr_c | (state_q == S_IDLE));
        rd_fire_c   = bus.req_valid & req_ready_c & ~bus.req_we;
        wr_fire_c   = bus.req_valid & req_ready_c & bus.req_we;
    end

    // Read data mux; unmapped addresses return zero
    always_comb begin
        rd_data_c = '0;
        if (is_kernel_c) begin
            for (int i = 0; i < N_TAPS; i++) begin
                rd_data_c[i*ELEM_W +: ELEM_W] = kern_q[i];
            end
        end else if (is_data_c) begin
            rd_data_c[ELEM_W-1:0] = win_q[0];
        end else if (is_state_c) begin
            rd_data_c[0]          = done_q;
            rd_data_c[1]          = busy;
            rd_data_c[32 +: CNT_W] = cnt_q;
        end else if (is_res_lo_c) begin
            rd_data_c = DATA_W'(result_q);
        end else if (is_res_hi_c) begin
            rd_data_c = DATA_W'(result_q >> 64);
        end
    end

`ifdef CONV_SIGNED_EN
    logic signed [PROD_W-1:0] prod_s_c;

    // Current tap product, two's-complement and sign-extended to the accumulator
    always_comb begin
        k_el_c   = kern_q[idx_q];
        w_el_c   = win_q[idx_q];
        prod_s_c = PROD_W'($signed(k_el_c)) * PROD_W'($signed(w_el_c));
        term_c   = RES_W'(prod_s_c);
    end
`else
    logic [PROD_W-1:0] prod_u_c;

    // Current tap product, unsigned and zero-extended to the accumulator
    always_comb begin
        k_el_c   = kern_q[idx_q];
        w_el_c   = win_q[idx_q];
        prod_u_c = PROD_W'(k_el_c) * PROD_W'(w_el_c);
        term_c   = RES_W'(prod_u_c);
    end
`endif

    // Control FSM, register file and read response pipeline
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                kern_q[i] <= '0;
                win_q[i]  <= '0;
            end
        end else begin
            resp_valid_q <= rd_fire_c;
            resp_rdata_q <= rd_fire_c ? rd_data_c : '0;

            case (state_q)
                S_IDLE: begin
                    if (wr_fire_c) begin
                        if (is_kernel_c) begin
                            for (int i = 0; i < N_TAPS; i++) begin
                                kern_q[i] <= bus.req_wdata[i*ELEM_W +: ELEM_W];
                            end
                        end else if (is_data_c) begin
                            win_q[0] <= bus.req_wdata[ELEM_W-1:0];
                            for (int i = 1; i < N_TAPS; i++) begin
                                win_q[i] <= win_q[i-1];
                            end
                            cnt_q   <= cnt_q + CNT_W'(1);
                            done_q  <= 1'b0;
                            acc_q   <= '0;
                            idx_q   <= '0;
                            state_q <= S_MAC;
                        end else if (is_state_c && bus.req_wdata[0]) begin
                            for (int i = 0; i < N_TAPS; i++) begin
                                win_q[i] <= '0;
                            end
                            result_q <= '0;
                            done_q   <= 1'b0;
                            cnt_q    <= '0;
                        end
                    end
                end

                S_MAC: begin
                    acc_q <= acc_q + term_c;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_TAPS - 1)) begin
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    result_q <= acc_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// tb_conv_mac_unit: scoreboard bench for conv_mac_unit. Read expectations are
// queued when a read is issued and checked when the response strobe appears.
module tb_conv_mac_unit;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned N_TAPS = 8;
    localparam int unsigned RES_W  = 128;
    localparam int          BOUND  = 100;

    localparam logic [11:0] A_KERNEL = 12'h000;
    localparam logic [11:0] A_DATA   = 12'h008;
    localparam logic [11:0] A_STATE  = 12'h010;
    localparam logic [11:0] A_RLO    = 12'h018;
    localparam logic [11:0] A_RHI    = 12'h020;
    localparam logic [11:0] A_UNMAP  = 12'h100;

    logic clk;
    logic rstn;
    logic busy;

    conv_mac_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    conv_mac_unit #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ELEM_W(ELEM_W),
        .N_TAPS(N_TAPS),
        .RES_W (RES_W)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    string       tag_q[$];
    logic [63:0] exp_q[$];
    string       mon_tag;
    logic [63:0] mon_exp;

    logic [7:0]   m_kern [N_TAPS];
    logic [7:0]   m_win  [N_TAPS];
    logic [31:0]  m_cnt;
    logic [127:0] m_res;
    logic         m_done;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response monitor: pop the oldest expectation on each response strobe
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_spurious", 128'(bus.resp_valid), 128'(0));
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check_eq(mon_tag, 128'(bus.resp_rdata), 128'(mon_exp));
            end
        end
    end

    function automatic logic [127:0] model_sum();
        logic [127:0] s;
        int ka, wa, p;
        s = '0;
        for (int i = 0; i < N_TAPS; i++) begin
`ifdef CONV_SIGNED_EN
            ka = int'($signed(m_kern[i]));
            wa = int'($signed(m_win[i]));
`else
            ka = int'({24'd0, m_kern[i]});
            wa = int'({24'd0, m_win[i]});
`endif
            p = ka * wa;
            s = s + {{96{p[31]}}, p};
        end
        return s;
    endfunction

    function automatic logic [63:0] state_exp(input logic b);
        return {m_cnt, 30'd0, b, m_done};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_TAPS; i++) begin
            m_kern[i] = '0;
            m_win[i]  = '0;
        end
        m_cnt  = '0;
        m_res  = '0;
        m_done = 1'b0;
    endtask

    task automatic model_kernel(input logic [63:0] k);
        for (int i = 0; i < N_TAPS; i++) m_kern[i] = k[i*8 +: 8];
    endtask

    // One bus transfer; stall = cycles spent waiting for req_ready
    task automatic xfer(input logic we, input logic [11:0] addr, input logic [63:0] wdata,
                        output int stall);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        stall = 0;
        #1;
        while (bus.req_ready !== 1'b1 && stall < BOUND) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (stall >= BOUND) check_eq("req_timeout", 128'(bus.req_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [63:0] e, input string tag);
        int s;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        xfer(1'b0, addr, 64'd0, s);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [63:0] d, output int stall);
        xfer(1'b1, addr, d, stall);
    endtask

    task automatic push(input logic [63:0] d);
        int s;
        xfer(1'b1, A_DATA, d, s);
        for (int i = N_TAPS - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = d[7:0];
        m_cnt    = m_cnt + 32'd1;
        m_done   = 1'b0;
    endtask

    // Wait for the pass to finish and commit the model result
    task automatic finish_pass();
        int c;
        c = 0;
        while (busy === 1'b1 && c < BOUND) begin
            @(negedge clk);
            c++;
        end
        if (c >= BOUND) check_eq("busy_timeout", 128'(busy), 128'(0));
        m_res  = model_sum();
        m_done = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        n_vec = 0;
        n_err = 0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rstn = 1'b0;
        model_reset();

        // Reset: a pending write must not be accepted
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = A_KERNEL;
        bus.req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_ready", 128'(bus.req_ready), 128'(0));
        end
        check_eq("rst_busy", 128'(busy), 128'(0));
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rd(A_STATE,  64'd0, "rst_state");
        rd(A_RLO,    64'd0, "rst_res_lo");
        rd(A_RHI,    64'd0, "rst_res_hi");
        rd(A_KERNEL, 64'd0, "rst_kernel");

        // Basic convolution
        wr(A_KERNEL, 64'h0102030405060708, s);
        model_kernel(64'h0102030405060708);
        rd(A_KERNEL, 64'h0102030405060708, "kernel_rb");
        push(64'd1);
        finish_pass();
        rd(A_RLO, 64'd8, "res_push1");
        push(64'd2);
        finish_pass();
        rd(A_RLO, 64'd23, "res_push2");
        rd(A_RHI, 64'd0, "res_hi_push2");
        rd(A_STATE, 64'h0000_0002_0000_0001, "state_cnt2");
        rd(A_DATA, 64'd2, "data_w0");

        // Kernel write stalls for the whole pass; result uses the old kernel
        push(64'd3);
        wr(A_KERNEL, 64'h1111111111111111, s);
        check_eq("kern_stall", 128'(s), 128'(N_TAPS + 1));
        finish_pass();
        model_kernel(64'h1111111111111111);
        rd(A_RLO, 64'd44, "res_old_kernel");
        rd(A_KERNEL, 64'h1111111111111111, "kernel_after_stall");

        // During a pass: RO write acked at once, reads see old result and busy
        push(64'd4);
        wr(A_RLO, 64'hFFFF_FFFF_FFFF_FFFF, s);
        check_eq("ro_wr_stall", 128'(s), 128'(0));
        rd(A_STATE, state_exp(1'b1), "state_in_mac");
        rd(A_RLO, m_res[63:0], "res_prev_in_mac");
        finish_pass();
        rd(A_RLO, m_res[63:0], "res_new_kernel");
        rd(A_STATE, state_exp(1'b0), "state_after_4");
        rd(A_UNMAP, 64'd0, "unmapped_rd");
        wr(A_UNMAP, 64'h1234, s);
        check_eq("unmapped_wr_stall", 128'(s), 128'(0));

        // All-ones kernel after a clear
        wr(A_KERNEL, 64'hFFFF_FFFF_FFFF_FFFF, s);
        model_kernel(64'hFFFF_FFFF_FFFF_FFFF);
        wr(A_STATE, 64'd1, s);
        for (int i = 0; i < N_TAPS; i++) m_win[i] = '0;
        m_cnt  = '0;
        m_res  = '0;
        m_done = 1'b0;
        rd(A_STATE, 64'd0, "state_cleared");
        rd(A_RLO, 64'd0, "res_cleared");
        rd(A_KERNEL, 64'hFFFF_FFFF_FFFF_FFFF, "kernel_kept");
        push(64'h02);
        finish_pass();
`ifdef CONV_SIGNED_EN
        rd(A_RLO, 64'hFFFF_FFFF_FFFF_FFFE, "neg_res_lo");
        rd(A_RHI, 64'hFFFF_FFFF_FFFF_FFFF, "neg_res_hi");
`else
        rd(A_RLO, 64'h1FE, "ff_res_lo");
        rd(A_RHI, 64'h0, "ff_res_hi");
`endif
        rd(A_STATE, 64'h0000_0001_0000_0001, "state_cnt1");

        // Reset in the third MAC cycle aborts the pass
        wr(A_KERNEL, 64'h0102030405060708, s);
        model_kernel(64'h0102030405060708);
        push(64'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_mac3", 128'(busy), 128'(1));
        rstn = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_mid_busy", 128'(busy), 128'(0));
        check_eq("rst_mid_ready", 128'(bus.req_ready), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        rd(A_RLO,    64'd0, "rst_mid_res");
        rd(A_DATA,   64'd0, "rst_mid_window");
        rd(A_STATE,  64'd0, "rst_mid_state");
        rd(A_KERNEL, 64'd0, "rst_mid_kernel");
        repeat (3) @(negedge clk);
        check_eq("busy_idle_end", 128'(busy), 128'(0));

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
